burst_line_port: RTL
====================

Name: burst_line_port

Overview:
- Upstream adapter between a cache/line client and the burst RAM interface (burst_ram_if).
- Client moves whole lines. A line is BURST_COUNT words of DATA_BITWIDTH bits.
- Block turns one line request into one burst command and streams write words. It also collects the read burst into a line.
- Sits between the cache controller and the RAM (emulator in simulation, vendor IP on hardware).

Parameters:
- LINE_ADDR_BITWIDTH, 2, width of line address; RAM word address width = LINE_ADDR_BITWIDTH + log2(BURST_COUNT).
- DATA_BITWIDTH, 64, RAM word width, divisible by 8.
- BURST_COUNT, 4, words per burst, power of 2 and >= 2. Line width LW = DATA_BITWIDTH*BURST_COUNT.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  client request valid
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  0: read line, 1: write line
- req_addr  in  LINE_ADDR_BITWIDTH  line address
- req_wdata  in  LW  line to write; word i = req_wdata[i*DATA_BITWIDTH +: DATA_BITWIDTH]
- rdata  out  LW  line read, same word packing
- rdata_valid  out  1  one-cycle pulse, rdata valid
- wr_done  out  1  one-cycle pulse, write burst fully driven
- br_cmd  out  1  0: read, 1: write
- br_cmd_en  out  1  command strobe
- br_addr  out  LINE_ADDR_BITWIDTH+log2(BURST_COUNT)  word address = {line addr, zeros}
- br_wr_data  out  DATA_BITWIDTH  write word
- br_data_mask  out  DATA_BITWIDTH/8  tied 0
- br_rd_data  in  DATA_BITWIDTH  read word
- br_rd_data_ready  in  1  br_rd_data valid
- br_busy  in  1  RAM busy

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. All state clears to IDLE.
- Reset values: br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, rdata=0, rdata_valid=0, wr_done=0, word counter=0.
- Reset mid-burst abandons the burst; no pulse is emitted. The RAM shares the same rst.
- All outputs are registered except req_ready.
- req_ready = (state==IDLE) & !br_busy & !rst. A request is accepted when req_valid & req_ready.
- On accept, the block latches req_write, req_addr and req_wdata, then goes to ISSUE.
- States:
  - IDLE: wait for accept.
  - ISSUE: one cycle. br_cmd_en=1, br_cmd=latched write flag, br_addr={addr, log2(BURST_COUNT) zeros}. For a write, br_wr_data=word0. Next state is WR_STREAM for a write, RD_COLLECT for a read.
  - WR_STREAM: BURST_COUNT-1 consecutive cycles driving words 1..BURST_COUNT-1 on br_wr_data, br_cmd_en=0. The cycle after the last word, wr_done=1 for one cycle and state returns to IDLE.
  - RD_COLLECT: each cycle with br_rd_data_ready=1, store br_rd_data into word slot cnt and increment cnt. On the BURST_COUNT-th word, next cycle sets rdata_valid=1 for one cycle with the complete line, clears cnt, returns to IDLE.
- br_cmd_en is high for exactly one cycle per request and only in ISSUE.
- Write latency: accept at cycle T → cmd_en at T+1 → last word at T+BURST_COUNT → wr_done at T+BURST_COUNT+1.
- Read latency: last br_rd_data_ready at cycle R → rdata_valid at R+1.
- rdata holds its value until the next read completes. Partially filled slots are not visible on rdata before the pulse.
- br_rd_data_ready outside RD_COLLECT is ignored.
- Gaps in br_rd_data_ready are tolerated; the word counter only advances on valid cycles.
- br_busy is a registered RAM output, so it is still 0 in the cycle after br_cmd_en. The block does not re-issue because state != IDLE.
- After returning to IDLE, req_ready stays low until br_busy falls.
- Highest line address: br_addr covers words up to 2^width-1 exactly, with no wrap inside the block.
- No command queue; at most one outstanding request.

Test Plan:
- Write line addr 1 with words 0x11..11, 0x22..22, 0x33..33, 0x44..44 → br_cmd_en one cycle with br_addr=4, br_cmd=1. br_wr_data sequence 0x11.., 0x22.., 0x33.., 0x44.. on consecutive cycles; wr_done exactly once, one cycle after the 0x44.. word.
- Read line addr 1 after the previous write → br_cmd=0, br_addr=4. rdata_valid pulses once, one cycle after the 4th br_rd_data_ready; rdata equals the written line with word0 in the low 64 bits.
- Hold req_valid=1 back to back (write addr 3, then read addr 3) → second accept only after br_busy low. br_addr=12 both times; read returns the written line; only one cmd_en per request.
- req_valid during RAM initialisation (br_busy=1 after reset) → req_ready=0, no br_cmd_en until br_busy drops; then accepted.
- Assert rst two cycles into a read's RD_COLLECT → all outputs at reset values next cycle, no rdata_valid pulse. A subsequent read of addr 0 completes normally.
- Spurious br_rd_data_ready while IDLE, and a one-cycle gap mid-burst in the model → IDLE pulse ignored; line assembled correctly, rdata_valid exactly once.

Source files
------------

// File: rtl/burst_line_port.sv
// burst_line_port: adapts whole-line client requests to a burst RAM port.
// A write line becomes one write command followed by a stream of its words.
// A read command's returned words are gathered into one line, which is then
// presented with a single-cycle pulse.
//
// Client handshake: a request transfers on a cycle where req_valid and
// req_ready are both high. req_ready is the only combinational output. It is
// high only while idle, with the RAM not busy and reset released.
// req_write, req_addr and req_wdata are captured on that cycle and may change
// afterwards. The block holds at most one outstanding request.
module burst_line_port #(
   parameter int LINE_ADDR_BITWIDTH = 2,
   parameter int DATA_BITWIDTH      = 64,
   parameter int BURST_COUNT        = 4,
   localparam int CW = $clog2(BURST_COUNT),
   localparam int AW = LINE_ADDR_BITWIDTH + CW,
   localparam int LW = DATA_BITWIDTH * BURST_COUNT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [LINE_ADDR_BITWIDTH-1:0] req_addr,
   input  logic [LW-1:0]                 req_wdata,
   output logic [LW-1:0]                 rdata,
   output logic                          rdata_valid,
   output logic                          wr_done,
   output logic                          br_cmd,
   output logic                          br_cmd_en,
   output logic [AW-1:0]                 br_addr,
   output logic [DATA_BITWIDTH-1:0]      br_wr_data,
   output logic [DATA_BITWIDTH/8-1:0]    br_data_mask,
   input  logic [DATA_BITWIDTH-1:0]      br_rd_data,
   input  logic                          br_rd_data_ready,
   input  logic                          br_busy,
   output logic [1:0]                    o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_ISSUE      = 2'd1,
      S_WR_STREAM  = 2'd2,
      S_RD_COLLECT = 2'd3
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(BURST_COUNT - 1);

   state_t                   r_state;
   logic                     r_write;
   logic [LW-1:0]            r_wdata;
   logic [CW-1:0]            r_cnt;
   logic [LW-1:0]            r_buf;
   logic [LW-1:0]            r_rdata;
   logic                     r_rdata_valid;
   logic                     r_wr_done;
   logic                     r_cmd;
   logic                     r_cmd_en;
   logic [AW-1:0]            r_addr;
   logic [DATA_BITWIDTH-1:0] r_wr_data;

   logic                     w_accept;
   logic [CW-1:0]            w_next_idx;
   logic [DATA_BITWIDTH-1:0] w_next_word;
   logic [LW-1:0]            w_fill;

   assign req_ready    = (r_state == S_IDLE) & ~br_busy & ~rst;
   assign w_accept     = req_valid & req_ready;
   assign w_next_idx   = r_cnt + CW'(1);
   assign w_next_word  = r_wdata[int'(w_next_idx)*DATA_BITWIDTH +: DATA_BITWIDTH];

   assign rdata        = r_rdata;
   assign rdata_valid  = r_rdata_valid;
   assign wr_done      = r_wr_done;
   assign br_cmd       = r_cmd;
   assign br_cmd_en    = r_cmd_en;
   assign br_addr      = r_addr;
   assign br_wr_data   = r_wr_data;
   assign br_data_mask = '0;
   assign o_dbg_state  = r_state;

   // Collect buffer with the incoming read word placed in the current slot.
   always_comb begin
      w_fill = r_buf;
      w_fill[int'(r_cnt)*DATA_BITWIDTH +: DATA_BITWIDTH] = br_rd_data;
   end

   // Request sequencer: issue one command, then stream or collect the burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_write       <= 1'b0;
         r_wdata       <= '0;
         r_cnt         <= '0;
         r_buf         <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_wr_done     <= 1'b0;
         r_cmd         <= 1'b0;
         r_cmd_en      <= 1'b0;
         r_addr        <= '0;
         r_wr_data     <= '0;
      end else begin
         r_cmd_en      <= 1'b0;
         r_wr_done     <= 1'b0;
         r_rdata_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_write  <= req_write;
                  r_wdata  <= req_wdata;
                  r_cnt    <= '0;
                  r_cmd_en <= 1'b1;
                  r_cmd    <= req_write;
                  r_addr   <= {req_addr, {CW{1'b0}}};
                  if (req_write) begin
                     r_wr_data <= req_wdata[DATA_BITWIDTH-1:0];
                  end
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_write) begin
                  r_wr_data <= w_next_word;
                  r_cnt     <= w_next_idx;
                  r_state   <= S_WR_STREAM;
               end else begin
                  r_cnt     <= '0;
                  r_state   <= S_RD_COLLECT;
               end
            end
            S_WR_STREAM: begin
               if (r_cnt == LAST) begin
                  r_wr_done <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_wr_data <= w_next_word;
                  r_cnt     <= w_next_idx;
               end
            end
            S_RD_COLLECT: begin
               if (br_rd_data_ready) begin
                  r_buf <= w_fill;
                  if (r_cnt == LAST) begin
                     r_rdata       <= w_fill;
                     r_rdata_valid <= 1'b1;
                     r_cnt         <= '0;
                     r_state       <= S_IDLE;
                  end else begin
                     r_cnt <= w_next_idx;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
